lif_scheduler: RTL

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_pkg.sv | 19 +
 rtl/lif_scheduler_if.sv | 18 +
 rtl/lif_update.sv | 41 ++++
 rtl/lif_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg
// Shared definitions for the LIF neuron scheduler: FSM state encoding,
// membrane state width and default leak / threshold parameters.
package lif_pkg;

   localparam int STATE_W = 8;

   localparam int              DEFAULT_BETA_SHIFT = 1;
   localparam logic [STATE_W-1:0] DEFAULT_THRESHOLD = 8'd200;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_UPDATE = 3'd2,
      ST_WRITE  = 3'd3,
      ST_DONE   = 3'd4
   } lif_state_e;

endpackage

// File: rtl/lif_scheduler_if.sv
// lif_scheduler_if
// Input-current fetch handshake between the scheduler and a current source.
//   cur_req   : scheduler requests current for neuron cur_idx
//   cur_idx   : neuron index being fetched
//   cur_valid : source has current available (transfer when req && valid)
//   cur_data  : unsigned 8-bit input current
// master = scheduler side, slave = current source side.
interface lif_scheduler_if #(
   parameter int IDX_W = 2
);
   logic             cur_req;
   logic [IDX_W-1:0] cur_idx;
   logic             cur_valid;
   logic [7:0]       cur_data;

   modport master (output cur_req, output cur_idx, input cur_valid, input cur_data);
   modport slave  (input cur_req, input cur_idx, output cur_valid, output cur_data);
endinterface

// File: rtl/lif_update.sv
// lif_update
// Combinational leak / integrate / fire step for one neuron.
//   i_state   : current membrane state
//   i_current : input current for this timestep
//   o_next    : state to store (0 after a spike)
//   o_spike   : neuron fires this timestep
module lif_update
   import lif_pkg::*;
#(
   parameter int                 BETA_SHIFT = DEFAULT_BETA_SHIFT,
   parameter logic [STATE_W-1:0] THRESHOLD  = DEFAULT_THRESHOLD
) (
   input  logic [STATE_W-1:0] i_state,
   input  logic [STATE_W-1:0] i_current,
   output logic [STATE_W-1:0] o_next,
   output logic               o_spike
);

   logic [STATE_W-1:0] w_leaked;
   logic [STATE_W:0]   w_sum;
   logic [STATE_W-1:0] w_sat;

   // Leak never underflows (shifted value <= state); sum is one bit wider and clamps at 255.
   always_comb begin
      w_leaked = i_state - (i_state >> BETA_SHIFT);
      w_sum    = {1'b0, w_leaked} + {1'b0, i_current};
      if (w_sum[STATE_W]) begin
         w_sat = {STATE_W{1'b1}};
      end else begin
         w_sat = w_sum[STATE_W-1:0];
      end
      if (w_sat >= THRESHOLD) begin
         o_spike = 1'b1;
         o_next  = {STATE_W{1'b0}};
      end else begin
         o_spike = 1'b0;
         o_next  = w_sat;
      end
   end

endmodule

// File: rtl/lif_scheduler.sv
// lif_scheduler
// Time-multiplexes N_NEURONS leaky integrate-and-fire neurons onto one
// lif_update datapath. One timestep = FETCH/UPDATE/WRITE per neuron, then DONE.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a timestep (only honoured in IDLE)
//   cur_if     : current fetch handshake (master side)
//   busy       : high outside IDLE
//   done       : one-cycle pulse when the timestep completes
//   spikes     : spike vector of the last completed timestep
//   rd_idx     : membrane readout select
//   rd_state   : registered membrane state of neuron rd_idx
module lif_scheduler
   import lif_pkg::*;
#(
   parameter int                 N_NEURONS  = 4,
   parameter int                 BETA_SHIFT = DEFAULT_BETA_SHIFT,
   parameter logic [STATE_W-1:0] THRESHOLD  = DEFAULT_THRESHOLD
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   lif_scheduler_if.master              cur_if,
   output logic                         busy,
   output logic                         done,
   output logic [N_NEURONS-1:0]         spikes,
   input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
   output logic [STATE_W-1:0]           rd_state
);

   localparam int IDX_W = $clog2(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   lif_state_e          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [STATE_W-1:0]  r_cur;
   logic [STATE_W-1:0]  r_new_state;
   logic [STATE_W-1:0]  r_states [N_NEURONS];
   logic [N_NEURONS-1:0] r_spk_acc;
   logic [N_NEURONS-1:0] r_spikes;
   logic                r_cur_req;
   logic                r_busy;
   logic                r_done;
   logic [STATE_W-1:0]  r_rd_state;

   logic [STATE_W-1:0]  w_cur_state;
   logic [STATE_W-1:0]  w_next;
   logic                w_spike;

   assign w_cur_state = r_states[r_idx];

   lif_update #(
      .BETA_SHIFT (BETA_SHIFT),
      .THRESHOLD  (THRESHOLD)
   ) u_update (
      .i_state   (w_cur_state),
      .i_current (r_cur),
      .o_next    (w_next),
      .o_spike   (w_spike)
   );

   // Scheduler FSM, state register file and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_cur       <= 8'd0;
         r_new_state <= 8'd0;
         r_spk_acc   <= '0;
         r_spikes    <= '0;
         r_cur_req   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         for (int k = 0; k < N_NEURONS; k++) begin
            r_states[k] <= 8'd0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_FETCH;
                  r_idx     <= '0;
                  r_spk_acc <= '0;
                  r_cur_req <= 1'b1;
                  r_busy    <= 1'b1;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               // Request and index stay put until the source delivers.
               if (cur_if.cur_valid) begin
                  r_cur     <= cur_if.cur_data;
                  r_cur_req <= 1'b0;
                  r_state   <= ST_UPDATE;
               end else begin
                  r_state   <= ST_FETCH;
               end
            end
            ST_UPDATE: begin
               r_new_state      <= w_next;
               r_spk_acc[r_idx] <= w_spike;
               r_state          <= ST_WRITE;
            end
            ST_WRITE: begin
               r_states[r_idx] <= r_new_state;
               if (r_idx == LAST_IDX) begin
                  // Publish the whole vector at once so partial results never show.
                  r_spikes <= r_spk_acc;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  r_idx     <= r_idx + IDX_W'(1);
                  r_cur_req <= 1'b1;
                  r_state   <= ST_FETCH;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_cur_req <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   // Membrane readout; forwards the value being written so readers see it one edge earlier.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_state <= 8'd0;
      end else if ((r_state == ST_WRITE) && (rd_idx == r_idx)) begin
         r_rd_state <= r_new_state;
      end else begin
         r_rd_state <= r_states[rd_idx];
      end
   end

   assign cur_if.cur_req = r_cur_req;
   assign cur_if.cur_idx = r_idx;
   assign busy           = r_busy;
   assign done           = r_done;
   assign spikes         = r_spikes;
   assign rd_state       = r_rd_state;

endmodule
